// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: owns the program counter, fetches one instruction at a time
// over a req/ack handshake, holds it for the decoder, and advances the PC
// (sequential / jump / register jump / branch) when execute completes.
// Only one instruction is in flight: fetch and execute never overlap.
module pc_fetch_unit #(
    parameter int                ADDR_W   = 32,  // fixed at 32
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic              instr_valid,
    input  logic              exec_ready,
    input  logic [2:0]        pc_control,
    input  logic [ADDR_W-1:0] rs_data,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic [31:0]       retired,
    output logic              ctrl_err
);

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

    localparam logic [2:0] PC_SEQ    = 3'b000;
    localparam logic [2:0] PC_JUMP   = 3'b001;
    localparam logic [2:0] PC_JR     = 3'b010;
    localparam logic [2:0] PC_BRANCH = 3'b011;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [31:0]       retired_q, retired_d;
    logic              ctrl_err_q, ctrl_err_d;

    logic [ADDR_W-1:0] pc_plus4_w;
    logic [ADDR_W-1:0] jump_target;
    logic [ADDR_W-1:0] branch_off;
    logic [ADDR_W-1:0] next_pc;
    logic              next_err;

    // State register; reset forces S_RESET regardless of any in-flight handshake.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: reset -> fetch -> issue -> fetch ...
    always_comb begin
        // NOTE: default assignment first so no path through the block
        // leaves state_d unassigned (which would infer a latch).
        state_d = state_q;
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: if (imem_ack)   state_d = S_ISSUE;
            S_ISSUE: if (exec_ready) state_d = S_FETCH;
            default: state_d = S_RESET;
        endcase
    end

    // Handshake outputs are decoded from the registered state only.
    always_comb begin
        imem_req    = (state_q == S_FETCH);
        instr_valid = (state_q == S_ISSUE);
    end

    // Next-PC candidates; the jump keeps the 256 MB region of pc + 4.
    always_comb begin
        pc_plus4_w  = pc_q + ADDR_W'(4);
        jump_target = {pc_plus4_w[ADDR_W-1 -: 4], instr_q[25:0], 2'b00};
        branch_off  = {{(ADDR_W-18){instr_q[15]}}, instr_q[15:0], 2'b00};
    end

    // Select the next PC from the decoder's pc_control; flag bad targets and codes.
    always_comb begin
        next_pc  = pc_plus4_w;
        next_err = 1'b0;
        case (pc_control)
            PC_SEQ:    next_pc = pc_plus4_w;
            PC_JUMP:   next_pc = jump_target;
            PC_JR: begin
                next_pc  = {rs_data[ADDR_W-1:2], 2'b00};
                next_err = |rs_data[1:0];
            end
            PC_BRANCH: next_pc = pc_plus4_w + branch_off;
            default:   next_err = 1'b1;  // reserved codes fall through sequentially
        endcase
    end

    // Datapath next-state: latch the word on ack, retire on exec_ready.
    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        retired_d  = retired_q;
        ctrl_err_d = ctrl_err_q;
        if (state_q == S_FETCH && imem_ack) begin
            instr_d = imem_rdata;
        end
        if (state_q == S_ISSUE && exec_ready) begin
            pc_d      = next_pc;
            retired_d = retired_q + 32'd1;
            if (next_err) begin
                ctrl_err_d = 1'b1;  // sticky until reset
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            retired_q  <= '0;
            ctrl_err_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            retired_q  <= retired_d;
            ctrl_err_q <= ctrl_err_d;
        end
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign pc_plus4  = pc_plus4_w;
    assign instr     = instr_q;
    assign retired   = retired_q;
    assign ctrl_err  = ctrl_err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit: directed scenarios plus a randomized run,
// all checked against a behavioural model of the PC rules.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        exec_ready;
    logic [2:0]  pc_control;
    logic [31:0] rs_data;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] retired;
    logic        ctrl_err;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state.
    logic [31:0] m_pc;
    logic [31:0] m_ret;
    logic        m_err;

    pc_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid),
        .exec_ready(exec_ready), .pc_control(pc_control), .rs_data(rs_data),
        .pc(pc), .pc_plus4(pc_plus4), .retired(retired), .ctrl_err(ctrl_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Behavioural model of one retirement.
    task automatic model_retire(input logic [31:0] ins, input logic [2:0] c, input logic [31:0] rs);
        logic [31:0] seq;
        int          off;
        seq = m_pc + 32'd4;
        if (c == 3'd0) begin
            m_pc = seq;
        end else if (c == 3'd1) begin
            m_pc = (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 4);
        end else if (c == 3'd2) begin
            m_pc = rs - (rs % 4);
            if (rs % 4 != 0) m_err = 1'b1;
        end else if (c == 3'd3) begin
            off  = $signed(ins[15:0]);
            m_pc = seq + 32'(off * 4);
        end else begin
            m_pc  = seq;
            m_err = 1'b1;
        end
        m_ret = m_ret + 32'd1;
    endtask

    task automatic model_reset();
        m_pc  = 32'h0;
        m_ret = 32'h0;
        m_err = 1'b0;
    endtask

    // Drive one fetch; called at a negedge, returns at the negedge after ack.
    task automatic do_fetch(input int ack_delay, input logic [31:0] rdata,
                            output logic [31:0] addr, output bit ok, output bit stable);
        int waited;
        waited = 0;
        ok     = 1'b1;
        stable = 1'b1;
        addr   = 32'h0;
        while (imem_req !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (imem_req !== 1'b1) begin
            ok = 1'b0;
            return;
        end
        addr = imem_addr;
        for (int i = 0; i < ack_delay; i++) begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            @(negedge clk);
            if (imem_req !== 1'b1 || imem_addr !== addr || instr_valid !== 1'b0) stable = 1'b0;
        end
        imem_ack   = 1'b1;
        imem_rdata = rdata;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        if (instr_valid !== 1'b1) ok = 1'b0;
    endtask

    // Drive one issue; called with instr_valid high, returns at the negedge after exec_ready.
    task automatic do_exec(input int exec_delay, input logic [2:0] c, input logic [31:0] rs,
                           input bit spurious, output bit stable);
        logic [31:0] i0, p0;
        stable     = 1'b1;
        i0         = instr;
        p0         = pc;
        pc_control = c;
        rs_data    = rs;
        for (int i = 0; i < exec_delay; i++) begin
            exec_ready = 1'b0;
            imem_ack   = spurious && (i == 1);
            imem_rdata = $urandom;
            @(negedge clk);
            if (instr !== i0 || pc !== p0 || instr_valid !== 1'b1 || imem_req !== 1'b0) stable = 1'b0;
        end
        imem_ack   = 1'b0;
        exec_ready = 1'b1;
        @(negedge clk);
        exec_ready = 1'b0;
        pc_control = 3'($urandom);
        rs_data    = $urandom;
    endtask

    // One complete instruction with the standard post-retire comparisons.
    task automatic run_instr(input string tag, input int ack_d, input logic [31:0] rdata,
                             input logic [2:0] c, input logic [31:0] rs, input int exec_d);
        logic [31:0] addr;
        bit ok, sf, se;
        do_fetch(ack_d, rdata, addr, ok, sf);
        n_total++;
        if (!ok) begin n_bad++; $display("FAIL %s fetch: no request or no instr_valid", tag); end
        n_total++;
        if (addr !== m_pc) begin n_bad++; $display("FAIL %s addr: got %h want %h", tag, addr, m_pc); end
        n_total++;
        if (instr !== rdata) begin n_bad++; $display("FAIL %s instr: got %h want %h", tag, instr, rdata); end
        do_exec(exec_d, c, rs, 1'b0, se);
        model_retire(rdata, c, rs);
        n_total++;
        if (pc !== m_pc) begin n_bad++; $display("FAIL %s pc: got %h want %h", tag, pc, m_pc); end
        n_total++;
        if (retired !== m_ret || ctrl_err !== m_err) begin
            n_bad++;
            $display("FAIL %s retired/err: got %0d/%b want %0d/%b", tag, retired, ctrl_err, m_ret, m_err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        model_reset();
        n_total++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset handshake: req=%b valid=%b want 0/0", imem_req, instr_valid);
        end
        n_total++;
        if (pc !== 32'h0 || instr !== 32'h0 || retired !== 32'h0 || ctrl_err !== 1'b0) begin
            n_bad++; $display("FAIL reset regs: pc=%h instr=%h ret=%0d err=%b want zeros", pc, instr, retired, ctrl_err);
        end
        rst = 1'b0;
        @(negedge clk);
        n_total++;
        if (imem_req !== 1'b1) begin n_bad++; $display("FAIL reset req_rise: got %b want 1", imem_req); end
    endtask

    task automatic test_sequential();
        for (int k = 0; k < 3; k++) begin
            run_instr("seq", 0, $urandom, 3'b000, 32'h0, 0);
        end
        n_total++;
        if (retired !== 32'd3 || pc !== 32'hC) begin
            n_bad++; $display("FAIL seq final: retired=%0d pc=%h want 3 / 0000000c", retired, pc);
        end
    endtask

    task automatic test_branch_back();
        run_instr("br_pre", 0, $urandom, 3'b000, 32'h0, 0);
        run_instr("br_back", 0, 32'h1234_FFFE, 3'b011, 32'h0, 0);
        n_total++;
        if (imem_addr !== 32'h0000_000C || ctrl_err !== 1'b0) begin
            n_bad++; $display("FAIL br_back target: addr=%h err=%b want 0000000c/0", imem_addr, ctrl_err);
        end
    endtask

    task automatic test_jump_jr();
        run_instr("jr_set", 0, $urandom, 3'b010, 32'h1000_0040, 0);
        run_instr("jump", 1, 32'h0800_0100, 3'b001, 32'h0, 1);
        n_total++;
        if (pc !== 32'h1000_0400) begin n_bad++; $display("FAIL jump target: got %h want 10000400", pc); end
        run_instr("jr_bad", 0, $urandom, 3'b010, 32'h0000_0203, 0);
        n_total++;
        if (pc !== 32'h0000_0200 || ctrl_err !== 1'b1) begin
            n_bad++; $display("FAIL jr_bad: pc=%h err=%b want 00000200/1", pc, ctrl_err);
        end
        run_instr("sticky1", 0, $urandom, 3'b000, 32'h0, 0);
        run_instr("sticky2", 2, $urandom, 3'b000, 32'h0, 1);
        n_total++;
        if (ctrl_err !== 1'b1) begin n_bad++; $display("FAIL err sticky: got %b want 1", ctrl_err); end
    endtask

    task automatic test_stalls();
        logic [31:0] addr, rdata, ret0;
        bit ok, sf, se;
        rdata = $urandom;
        ret0  = retired;
        do_fetch(3, rdata, addr, ok, sf);
        n_total++;
        if (!ok || !sf) begin n_bad++; $display("FAIL stall fetch: ok=%b stable=%b want 1/1", ok, sf); end
        n_total++;
        if (instr !== rdata) begin n_bad++; $display("FAIL stall instr: got %h want %h", instr, rdata); end
        do_exec(4, 3'b000, 32'h0, 1'b1, se);
        model_retire(rdata, 3'b000, 32'h0);
        n_total++;
        if (!se) begin n_bad++; $display("FAIL stall issue: instr/pc/handshake moved, stable=%b want 1", se); end
        n_total++;
        if (retired !== ret0 + 32'd1 || pc !== m_pc) begin
            n_bad++; $display("FAIL stall retire: ret=%0d pc=%h want %0d/%h", retired, pc, ret0 + 32'd1, m_pc);
        end
    endtask

    task automatic test_reset_mid();
        n_total++;
        if (imem_req !== 1'b1) begin n_bad++; $display("FAIL rstmid precond: req=%b want 1", imem_req); end
        rst        = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_ack = 1'b0;
        model_reset();
        n_total++;
        if (instr !== 32'h0 || pc !== 32'h0 || retired !== 32'h0 || ctrl_err !== 1'b0) begin
            n_bad++; $display("FAIL rstmid regs: instr=%h pc=%h ret=%0d err=%b want zeros", instr, pc, retired, ctrl_err);
        end
        n_total++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            n_bad++; $display("FAIL rstmid handshake: req=%b valid=%b want 0/0", imem_req, instr_valid);
        end
        rst = 1'b0;
        n_total++;
        if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rstmid via_reset: req=%b want 0", imem_req); end
        @(negedge clk);
        n_total++;
        if (imem_req !== 1'b1) begin n_bad++; $display("FAIL rstmid restart: req=%b want 1", imem_req); end
    endtask

    task automatic test_wrap_reserved();
        run_instr("wrap_set", 0, $urandom, 3'b010, 32'hFFFF_FFFC, 0);
        n_total++;
        if (pc_plus4 !== 32'h0) begin n_bad++; $display("FAIL wrap pc_plus4: got %h want 00000000", pc_plus4); end
        run_instr("wrap", 0, $urandom, 3'b000, 32'h0, 0);
        n_total++;
        if (pc !== 32'h0 || ctrl_err !== 1'b0) begin
            n_bad++; $display("FAIL wrap pc: pc=%h err=%b want 00000000/0", pc, ctrl_err);
        end
        run_instr("reserved", 0, $urandom, 3'b101, 32'h0, 0);
        n_total++;
        if (pc !== 32'h4 || ctrl_err !== 1'b1) begin
            n_bad++; $display("FAIL reserved: pc=%h err=%b want 00000004/1", pc, ctrl_err);
        end
    endtask

    task automatic test_random();
        logic [2:0]  c;
        logic [31:0] rs;
        for (int k = 0; k < 60; k++) begin
            c  = 3'($urandom_range(0, 7));
            rs = $urandom;
            if ($urandom_range(0, 3) != 0) rs[1:0] = 2'b00;
            run_instr("rand", $urandom_range(0, 3), $urandom, c, rs, $urandom_range(0, 3));
        end
    endtask

    initial begin
        rst        = 1'b1;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        exec_ready = 1'b0;
        pc_control = 3'b000;
        rs_data    = 32'h0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_sequential();
        test_branch_back();
        test_jump_jr();
        test_stalls();
        test_reset_mid();
        test_wrap_reserved();
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Owns the program counter and fetches instructions over a req/ack handshake.
- Presents each fetched word to the instruction decoder and holds it stable.
- Takes the decoder's combinational pc_control back and computes the next PC: sequential, jump, register jump or branch.
- Sits directly upstream of the decoder in the multi-cycle CPU.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded by reset.
- ADDR_W, 32, PC and instruction-memory address width. Fixed at 32; no other value is supported.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; equals pc.
- imem_ack  in  1  memory accepted the request; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  fetched instruction word.
- instr  out  32  held instruction word to the decoder.
- instr_valid  out  1  instr is valid and the unit is waiting for the execute stage.
- exec_ready  in  1  execute/writeback of the current instr completes this cycle.
- pc_control  in  3  from the decoder: 000 = seq, 001 = jump, 010 = jr, 011 = branch taken, 1xx = reserved.
- rs_data  in  32  register-file rs read value, used by jr.
- pc  out  32  current PC.
- pc_plus4  out  32  pc + 4, used for link writes.
- retired  out  32  count of completed instructions.
- ctrl_err  out  1  sticky error flag.

Behaviour:
- FSM states: S_RESET, S_FETCH, S_ISSUE. State is registered; imem_req and instr_valid are decoded from state only.
- While rst = 1 at an edge:
  - state <= S_RESET; pc <= RESET_PC; instr <= 0; retired <= 0; ctrl_err <= 0.
  - Outputs while in S_RESET: imem_req = 0, instr_valid = 0.
  - rst overrides everything, including an in-flight fetch or issue; any ack arriving during reset is dropped.
- S_RESET -> S_FETCH unconditionally on the first edge with rst = 0. imem_req rises one cycle after reset deasserts.
- S_FETCH:
  - imem_req = 1, imem_addr = pc. imem_req is held until ack.
  - On imem_ack = 1: instr <= imem_rdata; state <= S_ISSUE.
  - Minimum latency from imem_req rising to instr_valid is 1 cycle (ack in the first request cycle).
- S_ISSUE:
  - instr_valid = 1, imem_req = 0; instr and pc are held stable.
  - imem_ack is ignored outside S_FETCH.
  - On exec_ready = 1: pc <= next_pc; retired <= retired + 1 (wraps modulo 2^32); state <= S_FETCH.
  - exec_ready is ignored outside S_ISSUE.
- next_pc is combinational from pc, instr, pc_control and rs_data, sampled only on the S_ISSUE exec_ready edge:
  - 000: pc_plus4.
  - 001: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - 010: {rs_data[31:2], 2'b00}. If rs_data[1:0] != 0, set ctrl_err.
  - 011: pc_plus4 + (sign-extend(instr[15:0]) << 2), 32-bit wrap-around addition.
  - 1xx: pc_plus4, and set ctrl_err.
- pc_plus4 = pc + 4 modulo 2^32; 0xFFFF_FFFC wraps to 0.
- ctrl_err is sticky; only rst clears it.
- The unit never overlaps fetch and execute: one instruction is in flight at a time.

Test Plan:
- Reset and sequential fetch:
  - Stimulus: rst 2 cycles, ack always 1, exec_ready 1 on every issue, pc_control = 000.
  - Required: imem_req rises the cycle after rst falls; imem_addr = 0x0, 0x4, 0x8 on successive fetches; each instr matches rdata; retired = 3 after three issues.
- Branch backward:
  - Stimulus: pc = 0x10, instr[15:0] = 0xFFFE, pc_control = 011, exec_ready.
  - Required: next fetch address = 0x0C; ctrl_err = 0.
- Jump and jr:
  - Stimulus 1: pc = 0x1000_0040, instr[25:0] = 0x100, pc_control = 001. Required: pc = 0x1000_0400.
  - Stimulus 2: pc_control = 010, rs_data = 0x0000_0203. Required: pc = 0x0000_0200 and ctrl_err = 1, remaining 1 after further instructions.
- Handshake stalls:
  - Stimulus: ack delayed 3 cycles; exec_ready delayed 4 cycles; a spurious ack pulse during S_ISSUE.
  - Required: imem_req and imem_addr held stable during the wait; instr and pc stable through S_ISSUE; the spurious ack changes nothing; retired increments exactly once.
- Reset mid-operation:
  - Stimulus: assert rst while in S_FETCH with ack arriving in the same cycle.
  - Required: instr = 0, pc = RESET_PC, retired = 0, ctrl_err = 0; state restarts via S_RESET.
- Wrap and reserved code:
  - Stimulus 1: pc = 0xFFFF_FFFC, pc_control = 000. Required: next pc = 0x0.
  - Stimulus 2: pc_control = 101. Required: next pc = pc + 4 and ctrl_err = 1.
